apb2_bldc_requester: RTL

- APB2 requester (initiator) for the BLDC subsystem. It is the bus-driving end facing register completers such as the BLDC peripheral.
- Converts a simple valid/ready command/response interface into APB2 SETUP/ACCESS transfers.
- Supports unlimited wait states (`pready` low) and error reporting (`pslverr`).
- Intended users: test harnesses and on-chip controllers (sequencers, debug bridges) that program motor-control registers.

---
 rtl/apb2_bldc_requester.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/apb2_bldc_requester.sv
// ---------------------------------------------------------------------------
// apb2_bldc_requester
//
// APB2 requester for the BLDC subsystem. Turns a simple valid/ready
// command/response handshake into one APB2 SETUP/ACCESS transfer at a time.
// Wait states are unlimited by default. Completer errors are reported on
// rsp_err.
//
// Optional feature (compile-time macro APB2_BLDC_REQUESTER_TIMEOUT_EN):
//   When the macro is defined, an ACCESS phase that sees pready low for
//   timeout_cycles consecutive cycles is abandoned. The block then reports
//   rsp_err=1 with rsp_rdata=0. When the macro is undefined, ACCESS waits
//   forever for pready.
//
// Parameters:
//   data_width      APB data width, must be a multiple of 8
//   addr_width      APB address width
//   prot_value      constant driven on pprot
//   timeout_cycles  ACCESS wait-state limit (timeout build only)
//
// Ports:
//   pclk, preset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write, cmd_addr,          command fields, sampled only at the
//   cmd_wdata, cmd_strb           handshake
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            response payload (rdata is 0 for writes)
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb, pprot          APB requester outputs (all registered)
//   prdata, pready, pslverr       APB completer inputs
// ---------------------------------------------------------------------------
module apb2_bldc_requester #(
  parameter int         data_width     = 32,
  parameter int         addr_width     = 8,
  parameter logic [2:0] prot_value     = 3'b000,
  parameter int         timeout_cycles = 256
) (
  input  logic                    pclk,
  input  logic                    preset,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [addr_width-1:0]   cmd_addr,
  input  logic [data_width-1:0]   cmd_wdata,
  input  logic [data_width/8-1:0] cmd_strb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [data_width-1:0]   rsp_rdata,
  output logic                    rsp_err,

  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [addr_width-1:0]   paddr,
  output logic [data_width-1:0]   pwdata,
  output logic [data_width/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [data_width-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int strb_width = data_width / 8;

  // Transfer sequencer states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Reject parameter sets that cannot form whole byte lanes or a valid limit
  if ((data_width % 8) != 0 || data_width < 8) begin : g_bad_data_width
    $error("apb2_bldc_requester: data_width must be a non-zero multiple of 8");
  end
  if (timeout_cycles < 1) begin : g_bad_timeout
    $error("apb2_bldc_requester: timeout_cycles must be at least 1");
  end
  if (addr_width < 3) begin : g_bad_addr_width
    $error("apb2_bldc_requester: addr_width must be at least 3");
  end

  logic [1:0] state;

  // High for the one ACCESS cycle in which the transfer is abandoned because
  // the completer took too long. This is always low without the timeout build.
  logic timeout_hit;

`ifdef APB2_BLDC_REQUESTER_TIMEOUT_EN
  localparam int cnt_width = $clog2(timeout_cycles + 1);
  localparam logic [cnt_width-1:0] last_wait = cnt_width'(timeout_cycles - 1);

  logic [cnt_width-1:0] wait_count;

  // Count consecutive ACCESS cycles with pready low. The count restarts in
  // SETUP, so every transfer gets the full budget. When the count reaches
  // last_wait, the current cycle is the timeout_cycles-th wait state.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_count <= '0;
    end else if (state == SETUP) begin
      wait_count <= '0;
    end else if (state == ACCESS && !pready && wait_count != last_wait) begin
      wait_count <= wait_count + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !pready && (wait_count == last_wait);
`else
  assign timeout_hit = 1'b0;
`endif

  // Main sequencer. Every output is a register updated here. Reset and the
  // illegal-state recovery path both return the bus to an idle, selectable
  // condition. Reset also drops psel/penable on the next edge, which
  // abandons any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= prot_value;
    end else begin
      pprot <= prot_value;
      case (state)
        // Wait for a command. The address is forced word-aligned. Reads
        // never carry strobes, whatever the caller supplied.
        IDLE: begin
          cmd_ready <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            pwrite    <= cmd_write;
            paddr     <= {cmd_addr[addr_width-1:2], 2'b00};
            pwdata    <= cmd_wdata;
            pstrb     <= cmd_write ? cmd_strb : {strb_width{1'b0}};
            state     <= SETUP;
          end
        end

        // SETUP always lasts a single cycle. The address, data and strobes
        // stay as they are until the transfer ends.
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        // Hold the bus until the completer answers. pslverr and prdata only
        // have meaning in the cycle pready is high.
        ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? {data_width{1'b0}} : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        // Hold the response until it is consumed. Reopening cmd_ready here
        // means the next command can be accepted in the following IDLE cycle
        // at the earliest. This keeps psel low for at least two cycles.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule
